// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - i/j/k loop sequencer driving A/B operand reads, MAC and C writes
module matmul_sequencer #(
  parameter int DATA_W  = 32,
  parameter int DIM_W   = 5,
  parameter int MAX_DIM = 16,
  parameter int ADDR_W  = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start,
  input  logic [7:0]        op,
  input  logic [DIM_W-1:0]  w_a,
  input  logic [DIM_W-1:0]  h_a,
  input  logic [DIM_W-1:0]  w_b,
  input  logic [DIM_W-1:0]  h_b,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_re,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic              c_we,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RUN,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [DIM_W-1:0] LP_ONE = DIM_W'(1);
  localparam logic [DIM_W-1:0] LP_MAX = DIM_W'(MAX_DIM);
  localparam logic [7:0]       LP_OP_MATMUL = 8'd1;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_op;
  logic [DIM_W-1:0]  r_wa;
  logic [DIM_W-1:0]  r_ha;
  logic [DIM_W-1:0]  r_wb;
  logic [DIM_W-1:0]  r_hb;
  logic [DIM_W-1:0]  r_i;
  logic [DIM_W-1:0]  r_j;
  logic [DIM_W-1:0]  r_k;
  logic [DATA_W-1:0] r_acc;
  logic              r_rd_valid;
  logic              r_err;

  logic              w_reject;
  logic              w_k_last;
  logic              w_j_last;
  logic              w_i_last;
  logic [DATA_W-1:0] w_prod;

  // Any zero or oversize dimension, mismatched inner dimension, or unknown op kills the job.
  assign w_reject = (r_op != LP_OP_MATMUL) || (r_wa != r_hb) ||
                    (r_wa == '0) || (r_ha == '0) || (r_wb == '0) || (r_hb == '0) ||
                    (r_wa > LP_MAX) || (r_ha > LP_MAX) || (r_wb > LP_MAX) || (r_hb > LP_MAX);

  assign w_k_last = (r_k == r_wa - LP_ONE);
  assign w_j_last = (r_j == r_wb - LP_ONE);
  assign w_i_last = (r_i == r_ha - LP_ONE);

  // Low DATA_W bits of a product are identical for signed and unsigned operands, so the
  // truncated two's-complement product needs no sign extension.
  assign w_prod = a_data * b_data;

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign err    = r_err;
  assign mem_re = (r_state == S_RUN);
  assign c_we   = (r_state == S_WRITE);
  assign c_data = r_acc;
  assign a_addr = ADDR_W'(r_i) * ADDR_W'(r_wa) + ADDR_W'(r_k);
  assign b_addr = ADDR_W'(r_k) * ADDR_W'(r_wb) + ADDR_W'(r_j);
  assign c_addr = ADDR_W'(r_i) * ADDR_W'(r_wb) + ADDR_W'(r_j);

  // Next-state decode for the job sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CHECK;
      S_CHECK: w_next = w_reject ? S_DONE : S_RUN;
      S_RUN:   if (w_k_last) w_next = S_DRAIN;
      S_DRAIN: w_next = S_WRITE;
      S_WRITE: w_next = (w_i_last && w_j_last) ? S_DONE : S_RUN;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, latched job parameters, loop counters and the multiply-accumulate register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_wa       <= '0;
      r_ha       <= '0;
      r_wb       <= '0;
      r_hb       <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rd_valid <= (r_state == S_RUN);
      if (r_rd_valid) r_acc <= r_acc + w_prod;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op  <= op;
            r_wa  <= w_a;
            r_ha  <= h_a;
            r_wb  <= w_b;
            r_hb  <= h_b;
            r_err <= 1'b0;
          end
        end
        S_CHECK: begin
          r_i   <= '0;
          r_j   <= '0;
          r_k   <= '0;
          r_acc <= '0;
          if (w_reject) r_err <= 1'b1;
        end
        S_RUN: begin
          r_k <= r_k + LP_ONE;
        end
        S_WRITE: begin
          r_acc <= '0;
          r_k   <= '0;
          if (w_j_last) begin
            r_j <= '0;
            r_i <= w_i_last ? '0 : r_i + LP_ONE;
          end else begin
            r_j <= r_j + LP_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - directed self-checking bench for matmul_sequencer
module tb_matmul_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  op;
  logic [4:0]  w_a, h_a, w_b, h_b;
  logic        busy, done, err, mem_re, c_we;
  logic [7:0]  a_addr, b_addr, c_addr;
  logic [31:0] a_data, b_data, c_data;

  logic [31:0] a_mem [256];
  logic [31:0] b_mem [256];

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [7:0]  wr_addr [$];
  logic [31:0] wr_data [$];

  int   lat;
  logic err_done;
  int   done_seen;

  matmul_sequencer dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .start(start),
    .op(op),
    .w_a(w_a),
    .h_a(h_a),
    .w_b(w_b),
    .h_b(h_b),
    .busy(busy),
    .done(done),
    .err(err),
    .mem_re(mem_re),
    .a_addr(a_addr),
    .b_addr(b_addr),
    .a_data(a_data),
    .b_data(b_data),
    .c_we(c_we),
    .c_addr(c_addr),
    .c_data(c_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read operand RAMs.
  always @(posedge clk) begin
    if (mem_re) begin
      a_data <= a_mem[a_addr];
      b_data <= b_mem[b_addr];
    end
  end

  // Log C writes and count operand reads.
  always @(negedge clk) begin
    if (c_we) begin
      wr_addr.push_back(c_addr);
      wr_data.push_back(c_data);
      wr_cnt++;
    end
    if (mem_re) rd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int n = 0; n < 256; n++) begin
      a_mem[n] = 32'd0;
      b_mem[n] = 32'd0;
    end
  endtask

  task automatic run_job(input string name, input logic [7:0] op_v, input int wa, input int ha,
                         input int wb, input int hb, input int mid,
                         output int latency, output logic err_at_done);
    int wa_v, ha_v, wb_v, hb_v;
    wa_v = wa; ha_v = ha; wb_v = wb; hb_v = hb;
    @(negedge clk);
    wr_cnt = 0;
    rd_cnt = 0;
    wr_addr.delete();
    wr_data.delete();
    start = 1'b1;
    op  = op_v;
    w_a = wa_v[4:0];
    h_a = ha_v[4:0];
    w_b = wb_v[4:0];
    h_b = hb_v[4:0];
    latency = -1;
    err_at_done = 1'b0;
    for (int n = 1; n <= 6000; n++) begin
      @(negedge clk);
      start = (mid != 0) && (n == mid);
      if (start) begin
        op = 8'd1; w_a = 5'd3; h_a = 5'd4; w_b = 5'd5; h_b = 5'd3;
      end
      if (n == 1) check({name, "_busy"}, {31'd0, busy}, 32'd1);
      if (done) begin
        latency = n;
        err_at_done = err;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic load_s1();
    clear_mem();
    a_mem[0] = -32'sd3; a_mem[1] = -32'sd15; a_mem[2] = -32'sd6;  a_mem[3] = 32'sd7;
    b_mem[0] = 32'sd9;  b_mem[1] = -32'sd15; b_mem[2] = -32'sd2;  b_mem[3] = -32'sd5;
  endtask

  task automatic check_s1(input string name);
    check({name, "_lat"}, lat, 32'd18);
    check({name, "_err"}, {31'd0, err_done}, 32'd0);
    check({name, "_wcnt"}, wr_cnt, 32'd4);
    check({name, "_a0"}, {24'd0, wr_addr[0]}, 32'd0);
    check({name, "_d0"}, wr_data[0], 32'd3);
    check({name, "_a1"}, {24'd0, wr_addr[1]}, 32'd1);
    check({name, "_d1"}, wr_data[1], 32'd120);
    check({name, "_a2"}, {24'd0, wr_addr[2]}, 32'd2);
    check({name, "_d2"}, wr_data[2], -32'sd68);
    check({name, "_a3"}, {24'd0, wr_addr[3]}, 32'd3);
    check({name, "_d3"}, wr_data[3], 32'd55);
    check({name, "_rcnt"}, rd_cnt, 32'd8);
  endtask

  task automatic check_reject(input string name);
    check({name, "_lat"}, lat, 32'd2);
    check({name, "_err"}, {31'd0, err_done}, 32'd1);
    check({name, "_rcnt"}, rd_cnt, 32'd0);
    check({name, "_wcnt"}, wr_cnt, 32'd0);
  endtask

  task automatic check_idle_zero(input string name);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_done"}, {31'd0, done}, 32'd0);
    check({name, "_err"}, {31'd0, err}, 32'd0);
    check({name, "_mem_re"}, {31'd0, mem_re}, 32'd0);
    check({name, "_c_we"}, {31'd0, c_we}, 32'd0);
    check({name, "_a_addr"}, {24'd0, a_addr}, 32'd0);
    check({name, "_b_addr"}, {24'd0, b_addr}, 32'd0);
    check({name, "_c_addr"}, {24'd0, c_addr}, 32'd0);
    check({name, "_c_data"}, c_data, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 8'd0;
    w_a = 5'd0; h_a = 5'd0; w_b = 5'd0; h_b = 5'd0;
    a_data = 32'd0; b_data = 32'd0;
    clear_mem();
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;

    load_s1();
    run_job("s1", 8'd1, 2, 2, 2, 2, 0, lat, err_done);
    check_s1("s1");
    @(negedge clk);
    check("s1_busy_after", {31'd0, busy}, 32'd0);

    clear_mem();
    a_mem[0] = 32'd1; a_mem[1] = 32'd2; a_mem[2] = 32'd3;
    b_mem[0] = 32'd4; b_mem[1] = 32'd5; b_mem[2] = 32'd6;
    run_job("s2", 8'd1, 3, 1, 1, 3, 0, lat, err_done);
    check("s2_lat", lat, 32'd7);
    check("s2_wcnt", wr_cnt, 32'd1);
    check("s2_addr", {24'd0, wr_addr[0]}, 32'd0);
    check("s2_data", wr_data[0], 32'd32);

    run_job("s3_dim", 8'd1, 3, 2, 2, 2, 0, lat, err_done);
    check_reject("s3_dim");
    @(negedge clk);
    check("s3_err_held", {31'd0, err}, 32'd1);
    check("s3_busy_idle", {31'd0, busy}, 32'd0);
    run_job("s3_op", 8'd2, 2, 2, 2, 2, 0, lat, err_done);
    check_reject("s3_op");
    run_job("s3_big", 8'd1, 17, 2, 2, 17, 0, lat, err_done);
    check_reject("s3_big");
    run_job("s3_zero", 8'd1, 2, 0, 2, 2, 0, lat, err_done);
    check_reject("s3_zero");

    clear_mem();
    a_mem[0] = 32'h7FFF_FFFF;
    b_mem[0] = 32'd2;
    run_job("s4", 8'd1, 1, 1, 1, 1, 0, lat, err_done);
    check("s4_lat", lat, 32'd5);
    check("s4_err_cleared", {31'd0, err_done}, 32'd0);
    check("s4_wcnt", wr_cnt, 32'd1);
    check("s4_data", wr_data[0], 32'hFFFF_FFFE);

    load_s1();
    run_job("s5", 8'd1, 2, 2, 2, 2, 5, lat, err_done);
    check_s1("s5");

    @(negedge clk);
    start = 1'b1; op = 8'd1;
    w_a = 5'd16; h_a = 5'd16; w_b = 5'd16; h_b = 5'd16;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("s6_in_run", {31'd0, mem_re}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_zero("s6_rst");
    rst = 1'b0;
    wr_cnt = 0;
    done_seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("s6_no_write", wr_cnt, 32'd0);
    check("s6_no_done", done_seen, 32'd0);
    load_s1();
    run_job("s6_rerun", 8'd1, 2, 2, 2, 2, 0, lat, err_done);
    check_s1("s6_rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
